// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master = operand issuer / result consumer, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             busy;

  modport master (
    output in_valid, A, B, Sel, out_ready,
    input  in_ready, out_valid, Y, carry, overflow, zero, negative, busy
  );

  modport slave (
    input  in_valid, A, B, Sel, out_ready,
    output in_ready, out_valid, Y, carry, overflow, zero, negative, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked WIDTH-bit ALU with shifts/rotate, compare and a
// multi-cycle unsigned shift-add multiplier. One result register feeds the
// writeback stage; results leave in acceptance order.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_CMP  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   y_reg;
  logic               carry_reg;
  logic               overflow_reg;
  logic               zero_reg;
  logic               negative_reg;
  logic               out_valid_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;

  logic               in_ready_w;
  logic               accept;
  logic [WIDTH-1:0]   res_y;
  logic               res_c;
  logic               res_v;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] rol_tmp;
  logic [SHW-1:0]     sh_amt;
  logic               big_shift;

  // Accept only when idle and the result register is empty or draining now.
  assign in_ready_w = !rst && (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_reg;
  assign bus.Y         = y_reg;
  assign bus.carry     = carry_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;
  assign bus.negative  = negative_reg;
  assign bus.busy      = (state_reg == MUL);

  // WIDTH is a power of two, so B >= WIDTH exactly when any bit above the
  // shift-amount field is set.
  assign sh_amt    = bus.B[SHW-1:0];
  assign big_shift = |bus.B[WIDTH-1:SHW];

  // Single-cycle datapath: result and ADD/SUB flags for the presented op.
  always_comb begin
    res_y   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    sum     = {1'b0, bus.A} + {1'b0, bus.B};
    diff    = {1'b0, bus.A} - {1'b0, bus.B};
    rol_tmp = {bus.A, bus.A} << sh_amt;
    case (bus.Sel)
      OP_ADD: begin
        res_y = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        res_y = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  res_y = bus.A & bus.B;
      OP_OR:   res_y = bus.A | bus.B;
      OP_XOR:  res_y = bus.A ^ bus.B;
      OP_NAND: res_y = ~(bus.A & bus.B);
      OP_NOR:  res_y = ~(bus.A | bus.B);
      OP_XNOR: res_y = ~(bus.A ^ bus.B);
      OP_NOT:  res_y = ~bus.A;
      OP_SHL:  res_y = big_shift ? '0 : (bus.A << sh_amt);
      OP_SHR:  res_y = big_shift ? '0 : (bus.A >> sh_amt);
      OP_SRA:  res_y = big_shift ? {WIDTH{bus.A[WIDTH-1]}}
                                 : WIDTH'($signed(bus.A) >>> sh_amt);
      OP_ROL:  res_y = rol_tmp[2*WIDTH-1:WIDTH];
      OP_CMP: begin
        res_y[0] = $signed(bus.A) < $signed(bus.B);
        res_y[1] = bus.A < bus.B;
        res_y[2] = bus.A == bus.B;
      end
      default: res_y = '0;
    endcase
  end

  // Control FSM plus result register: single-cycle ops write on the accept
  // edge, MUL iterates WIDTH times and writes on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      negative_reg  <= 1'b0;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      // A consumed result frees the register unless a completion refills it below.
      if (bus.out_ready) out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.Sel == OP_MUL) begin
              mcand_reg  <= {{WIDTH{1'b0}}, bus.A};
              mplier_reg <= bus.B;
              acc_reg    <= '0;
              cnt_reg    <= CW'(WIDTH);
              state_reg  <= MUL;
            end else begin
              y_reg         <= res_y;
              carry_reg     <= res_c;
              overflow_reg  <= res_v;
              zero_reg      <= (res_y == '0);
              negative_reg  <= res_y[WIDTH-1];
              out_valid_reg <= 1'b1;
            end
          end
        end
        MUL: begin
          if (cnt_reg == '0) begin
            y_reg         <= acc_reg[WIDTH-1:0];
            carry_reg     <= |acc_reg[2*WIDTH-1:WIDTH];
            overflow_reg  <= |acc_reg[2*WIDTH-1:WIDTH];
            zero_reg      <= (acc_reg[WIDTH-1:0] == '0);
            negative_reg  <= acc_reg[WIDTH-1];
            out_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, handshaked successor to the combinational 4-bit ALU. It is generalised to WIDTH bits and adds amount-controlled shifts/rotates, a compare op, and a multi-cycle unsigned shift-add multiplier. Operands enter through a valid/ready input port and results leave through a valid/ready output register. It sits between the operand-issue logic and the result writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits; power of 2, minimum 4.
SHW, $clog2(WIDTH), localparam; number of B bits used as the shift amount.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand/opcode presented.
in_ready  out  1  block can accept an operation this cycle.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift/rotate ops.
Sel  in  4  opcode.
out_valid  out  1  result register holds an unconsumed result.
out_ready  in  1  downstream consumes the result.
Y  out  WIDTH  result.
carry  out  1  carry / borrow / multiply high-part-nonzero.
overflow  out  1  signed overflow, or multiply overflow.
zero  out  1  Y == 0.
negative  out  1  Y[WIDTH-1].
busy  out  1  multiply in progress.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst=1 at a clock edge, all of the following are 0 after that edge: state=IDLE, out_valid, Y, carry, overflow, zero, negative, busy. in_ready=0 while rst is high.
- Accept condition: in_ready = !rst & (state==IDLE) & (!out_valid | out_ready), combinational. An operation is accepted on any edge with in_valid & in_ready.
- Handshake ordering: results are delivered in acceptance order. Y and all flags are held stable while out_valid & !out_ready. out_valid clears on an edge with out_ready and no new completion.
- Opcodes:
  - 0000 ADD: {carry,Y}=A+B; overflow=(A,B same sign) & (Y sign differs from A).
  - 0001 SUB: {carry,Y}=A-B, where carry=borrow; overflow=(A,B signs differ) & (Y sign differs from A).
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NAND, 0110 NOR, 0111 XNOR.
  - 1000 NOT A.
  - 1001 SHL: A<<B. 1010 SHR: logical A>>B. 1011 SRA: arithmetic shift right.
  - For SHL/SHR/SRA the full B value is the shift amount. If B>=WIDTH: SHL/SHR give 0 and SRA gives WIDTH copies of A[WIDTH-1].
  - 1100 ROL: rotate A left by B[SHW-1:0], i.e. B mod WIDTH.
  - 1101 CMP: Y[0]=signed A<B, Y[1]=unsigned A<B, Y[2]=A==B, other bits 0.
  - 1110 MUL: unsigned A*B; Y=low WIDTH bits of the product; carry=overflow=|high WIDTH bits.
  - 1111 reserved: Y=0.
- Flags: carry and overflow are 0 for every op except ADD, SUB and MUL. zero and negative are always derived from the registered Y.
- Latency (single-cycle ops): every op except MUL produces its result in 1 cycle. The result is registered on the accept edge, so out_valid=1 the cycle after acceptance.
- FSM: IDLE, MUL, and an implicit hold of the output register.
  - IDLE -> MUL on accepting Sel=1110. The FSM latches A and B, clears a 2*WIDTH accumulator, and loads iteration counter = WIDTH.
  - MUL: each cycle, if the multiplier LSB is 1, add the shifted multiplicand into the accumulator; then shift multiplier right and multiplicand left, and decrement the counter. busy=1 and in_ready=0 throughout.
  - When the counter reaches 0, write Y and flags, set out_valid, and return to IDLE.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge. The MUL completion is never blocked: the accept rule guarantees the output register is empty or being drained.
- Back-to-back: an op may be accepted in the same cycle the previous result is consumed (out_valid & out_ready). This sustains 1 op/cycle for non-MUL ops.
- Reset mid-operation: an in-flight MUL is discarded and no result is produced. A pending unconsumed result is dropped.
- Input rules: in_valid with in_ready=0 has no effect; the source must hold its operands. Sel/A/B values are don't-care when in_valid=0.

Test Plan:
- WIDTH=8, ADD A=0x7F B=0x01 -> next cycle out_valid=1, Y=0x80, carry=0, overflow=1, negative=1, zero=0. ADD 0xFF+0x01 -> Y=0x00, carry=1, zero=1.
- SUB A=0x00 B=0x01 -> Y=0xFF, carry=1, overflow=0. SUB 0x80-0x01 -> Y=0x7F, overflow=1.
- SRA A=0x90 B=2 -> Y=0xE4. SHL A=0x81 B=9 -> Y=0x00, zero=1. ROL A=0x81 B=9 -> Y=0x03. CMP A=0xFF B=0x01 -> Y=0x01 (signed less-than only).
- MUL 0x0F*0x11 -> Y=0xFF, carry=0, out_valid exactly 9 cycles after accept, busy=1 and in_ready=0 in between. MUL 0x10*0x10 -> Y=0x00, carry=1, overflow=1, zero=1.
- Backpressure: ADD result with out_ready=0 for 3 cycles -> Y/flags stable and in_ready=0. Raise out_ready with in_valid=1 (XOR queued) -> ADD consumed and XOR accepted on the same edge; XOR result appears the next cycle.
- rst=1 on cycle 4 of a MUL -> next cycle busy=0, out_valid=0, Y=0. No MUL result appears later, and in_ready=1 once rst is low.
